// File: rtl/cnn_pkg.sv
// Shared definitions for the cnn_conv_core convolution engine: FSM encoding,
// accumulator width, default kernel coefficient and the synthetic image generator.
package cnn_pkg;

    localparam int ACC_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } cnn_state_e;

    localparam logic signed [3:0] K_DEFAULT = 4'sd1;

    // The image is never stored: each pixel is recomputed from its coordinates.
    function automatic logic [7:0] pixel_at(input logic [7:0] row, input logic [7:0] col,
                                            input logic [7:0] ofs);
        logic [7:0] sum;
        sum = row + col + ofs;
        return sum;
    endfunction

endpackage

// File: rtl/cnn_mac.sv
// Signed multiply-accumulate: 8-bit unsigned pixel times 4-bit signed weight,
// accumulated into an ACC_W-bit signed register with synchronous clear.
module cnn_mac
    import cnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [7:0]              pix,
    input  logic signed [3:0]       weight,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [12:0]      prod;

    always_comb begin
        prod  = $signed({1'b0, pix}) * weight;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cnn_conv_core.sv
// 3x3 valid convolution over a generated 7x7 image; exports feature-map row 2.
// Optional build macro CNN_RELU_EN clamps negative results to zero before output.
module cnn_conv_core
    import cnn_pkg::*;
#(
    parameter int                IMG_W   = 7,
    parameter int                K       = 3,
    parameter int                OW      = 13,
    parameter logic [7:0]        PIX_OFS = 8'd0,
    parameter logic signed [3:0] K00     = K_DEFAULT,
    parameter logic signed [3:0] K01     = K_DEFAULT,
    parameter logic signed [3:0] K02     = K_DEFAULT,
    parameter logic signed [3:0] K10     = K_DEFAULT,
    parameter logic signed [3:0] K11     = K_DEFAULT,
    parameter logic signed [3:0] K12     = K_DEFAULT,
    parameter logic signed [3:0] K20     = K_DEFAULT,
    parameter logic signed [3:0] K21     = K_DEFAULT,
    parameter logic signed [3:0] K22     = K_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [OW-1:0] out31,
    output logic [OW-1:0] out32,
    output logic [OW-1:0] out33,
    output logic [OW-1:0] out34,
    output logic [OW-1:0] out35,
    output logic          done
);

    localparam int CW = $clog2(IMG_W);
    localparam int KW = $clog2(K);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MAC  = MAC;
    localparam logic [1:0] S_WR   = WR;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [CW-1:0] F_LAST   = CW'(IMG_W - K);
    localparam logic [CW-1:0] ROW_OUT  = CW'(2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OW) - 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        r_q, r_d, c_q, c_d;
    logic [KW-1:0]        i_q, i_d, j_q, j_d;
    logic [4:0][OW-1:0]   row_q, row_d;
    logic                 done_q, done_d;

    logic                    mac_en, mac_clr;
    logic [7:0]              pix;
    logic signed [3:0]       weight;
    logic [3:0]              kidx;
    logic signed [ACC_W-1:0] acc, acc_val;
    logic [OW-1:0]           out_conv;
    logic signed [3:0]       kern [0:8];

    assign kern = '{K00, K01, K02, K10, K11, K12, K20, K21, K22};

    always_comb begin
        kidx   = 4'(i_q) * 4'd3 + 4'(j_q);
        weight = kern[kidx];
        pix    = pixel_at(8'(r_q) + 8'(i_q), 8'(c_q) + 8'(j_q), PIX_OFS);
    end

    cnn_mac u_mac (
        .clk    (clk),
        .rst_n  (rst),
        .clear  (mac_clr),
        .en     (mac_en),
        .pix    (pix),
        .weight (weight),
        .acc    (acc)
    );

    // Without ReLU, negative sums pass through as their low OW bits.
    always_comb begin
        acc_val = acc;
`ifdef CNN_RELU_EN
        if (acc_val < 0) begin
            acc_val = '0;
        end
`endif
        if (acc_val > SAT_MAX) begin
            out_conv = '1;
        end else begin
            out_conv = acc_val[OW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        row_d   = row_q;
        done_d  = done_q;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                r_d     = '0;
                c_d     = '0;
                i_d     = '0;
                j_d     = '0;
                mac_clr = 1'b1;
                state_d = S_MAC;
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (j_q == K_LAST) begin
                    j_d = '0;
                    if (i_q == K_LAST) begin
                        i_d     = '0;
                        state_d = S_WR;
                    end else begin
                        i_d = i_q + KW'(1);
                    end
                end else begin
                    j_d = j_q + KW'(1);
                end
            end
            S_WR: begin
                mac_clr = 1'b1;
                if (r_q == ROW_OUT) begin
                    row_d[c_q] = out_conv;
                end
                if (c_q == F_LAST) begin
                    c_d = '0;
                    if (r_q == F_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        r_d     = r_q + CW'(1);
                        state_d = S_MAC;
                    end
                end else begin
                    c_d     = c_q + CW'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign out31 = row_q[0];
    assign out32 = row_q[1];
    assign out33 = row_q[2];
    assign out34 = row_q[3];
    assign out35 = row_q[4];
    assign done  = done_q;

endmodule

// File: tb/tb_cnn_conv_core.sv
// Directed, table-driven bench for cnn_conv_core: four parameterisations run side
// by side (default, negative centre tap, pixel offset, positive saturation).
module tb_cnn_conv_core;

    logic clk;
    logic rst;

    logic [4:0][12:0] defOut, negOut, ofsOut, satOut;
    logic             defDone, negDone, ofsDone, satDone;

    typedef struct {
        int          inst;
        int          col;
        logic [12:0] expected;
    } vec_t;

    vec_t vectors [20];
    int   checks = 0;
    int   passes = 0;

    cnn_conv_core dutDef (
        .clk(clk), .rst(rst),
        .out31(defOut[0]), .out32(defOut[1]), .out33(defOut[2]),
        .out34(defOut[3]), .out35(defOut[4]), .done(defDone)
    );

    cnn_conv_core #(
        .K00(4'sd0), .K01(4'sd0), .K02(4'sd0),
        .K10(4'sd0), .K11(-4'sd1), .K12(4'sd0),
        .K20(4'sd0), .K21(4'sd0), .K22(4'sd0)
    ) dutNeg (
        .clk(clk), .rst(rst),
        .out31(negOut[0]), .out32(negOut[1]), .out33(negOut[2]),
        .out34(negOut[3]), .out35(negOut[4]), .done(negDone)
    );

    cnn_conv_core #(.PIX_OFS(8'd200)) dutOfs (
        .clk(clk), .rst(rst),
        .out31(ofsOut[0]), .out32(ofsOut[1]), .out33(ofsOut[2]),
        .out34(ofsOut[3]), .out35(ofsOut[4]), .done(ofsDone)
    );

    cnn_conv_core #(
        .PIX_OFS(8'd240),
        .K00(4'sd7), .K01(4'sd7), .K02(4'sd7),
        .K10(4'sd7), .K11(4'sd7), .K12(4'sd7),
        .K20(4'sd7), .K21(4'sd7), .K22(4'sd7)
    ) dutSat (
        .clk(clk), .rst(rst),
        .out31(satOut[0]), .out32(satOut[1]), .out33(satOut[2]),
        .out34(satOut[3]), .out35(satOut[4]), .done(satDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] getOut(input int inst, input int col);
        case (inst)
            0:       return defOut[col];
            1:       return negOut[col];
            2:       return ofsOut[col];
            default: return satOut[col];
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs until the default instance raises done; returns the edge count (or -1).
    task automatic applyStimulus(output int edges);
        edges = 0;
        while (!defDone && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!defDone) begin
            edges = -1;
        end
    endtask

    task automatic checkTable(input string tag);
        for (int v = 0; v < 20; v++) begin
            checkOutput($sformatf("%s_inst%0d_out3%0d", tag, vectors[v].inst, vectors[v].col + 1),
                        int'(getOut(vectors[v].inst, vectors[v].col)),
                        int'(vectors[v].expected));
        end
    endtask

    initial begin
        int edges;
        int holdBad;

        for (int c = 0; c < 5; c++) begin
            vectors[c]      = '{0, c, 13'(36 + 9 * c)};
`ifdef CNN_RELU_EN
            vectors[5 + c]  = '{1, c, 13'd0};
`else
            vectors[5 + c]  = '{1, c, 13'(8188 - c)};
`endif
            vectors[10 + c] = '{2, c, 13'(1836 + 9 * c)};
            vectors[15 + c] = '{3, c, 13'd8191};
        end

        rst = 1'b0;
        #20;
        checkOutput("reset_done", int'(defDone), 0);
        checkOutput("reset_out31", int'(defOut[0]), 0);
        checkOutput("reset_out35", int'(defOut[4]), 0);
        #30;
        rst = 1'b1;

        applyStimulus(edges);
        checkOutput("done_latency", edges, 251);
        checkOutput("done_neg", int'(negDone), 1);
        checkOutput("done_ofs", int'(ofsDone), 1);
        checkOutput("done_sat", int'(satDone), 1);
        checkTable("run1");

        holdBad = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (!defDone) holdBad++;
            for (int c = 0; c < 5; c++) begin
                if (defOut[c] != vectors[c].expected) holdBad++;
            end
        end
        checkOutput("hold_stable_errors", holdBad, 0);

        // A short reset pulse while in DONE must restart the engine.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("glitch_done_clear", int'(defDone), 0);
        checkOutput("glitch_out33_clear", int'(defOut[2]), 0);
        @(negedge clk);
        rst = 1'b1;

        repeat (120) @(posedge clk);
        #1;
        checkOutput("mid_done_low", int'(defDone), 0);
        checkOutput("mid_out31_loaded", int'(defOut[0]), 36);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_out31", int'(defOut[0]), 0);
        checkOutput("mid_reset_done", int'(defDone), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        applyStimulus(edges);
        checkOutput("restart_latency", edges, 251);
        checkTable("run2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
